// File: rtl/cpu_action_gen.sv
// CPU opponent action picker: an LFSR feeds a programmable four-way threshold classifier.
// The game FSM pulls one decision at a time through a req/ack handshake with an optional cooldown.
module cpu_action_gen #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = {{(LFSR_W-1){1'b0}}, 1'b1},
  parameter int                HOLD_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic [7:0]        i_thr0,
  input  logic [7:0]        i_thr1,
  input  logic [7:0]        i_thr2,
  input  logic [HOLD_W-1:0] i_hold,
  input  logic              i_req,
  input  logic              i_ack,
  output logic              o_valid,
  output logic [1:0]        o_cpu_type,
  output logic              o_busy
);

  localparam logic [1:0] ACT_STANDBY = 2'b00;
  localparam logic [1:0] ACT_LIGHT   = 2'b01;
  localparam logic [1:0] ACT_HEAVY   = 2'b10;
  localparam logic [1:0] ACT_BLOCK   = 2'b11;

  typedef enum logic [1:0] {IDLE, VALID, COOL} state_t;

  state_t            state, state_n;
  logic [LFSR_W-1:0] lfsr, lfsr_n;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic              valid_n;
  logic [1:0]        type_n;
  logic [1:0]        act;
  logic [7:0]        r;
  logic              fb;

  // Maximal-length tap sets; only these widths are supported.
  generate
    if (LFSR_W == 8) begin : g_taps8
      assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    end else if (LFSR_W == 16) begin : g_taps16
      assign fb = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];
    end else if (LFSR_W == 32) begin : g_taps32
      assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
    end else begin : g_bad_width
      $error("cpu_action_gen: LFSR_W must be 8, 16 or 32");
    end
  endgenerate

  assign r = lfsr[LFSR_W-1 -: 8];

  always_comb begin
    if (r <= i_thr0)      act = ACT_STANDBY;
    else if (r <= i_thr1) act = ACT_LIGHT;
    else if (r <= i_thr2) act = ACT_HEAVY;
    else                  act = ACT_BLOCK;
  end

  // A zero seed would lock the LFSR, so it falls back to SEED.
  always_comb begin
    lfsr_n = lfsr;
    if (i_seed_load)   lfsr_n = (i_seed == '0) ? SEED : i_seed;
    else if (i_enable) lfsr_n = {lfsr[LFSR_W-2:0], fb};
  end

  always_comb begin
    state_n = state;
    valid_n = o_valid;
    type_n  = o_cpu_type;
    cnt_n   = cnt;
    case (state)
      IDLE: if (i_req) begin
        type_n  = act;
        valid_n = 1'b1;
        state_n = VALID;
      end
      VALID: if (i_ack) begin
        valid_n = 1'b0;
        if (i_hold == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n   = i_hold;
          state_n = COOL;
        end
      end
      COOL: begin
        // Leaving on the count==1 edge makes COOL last exactly i_hold cycles.
        if (cnt <= HOLD_W'(1)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      lfsr       <= SEED;
      cnt        <= '0;
      o_valid    <= 1'b0;
      o_cpu_type <= ACT_STANDBY;
    end else begin
      state      <= state_n;
      lfsr       <= lfsr_n;
      cnt        <= cnt_n;
      o_valid    <= valid_n;
      o_cpu_type <= type_n;
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_cpu_action_gen.sv
// Randomised bench for cpu_action_gen (8-bit LFSR build) against a cycle-level behavioural model.
module tb_cpu_action_gen;

  logic       clk, rst_n, en, sl, req, ack;
  logic [7:0] seed, thr0, thr1, thr2, hold;
  logic       valid, busy;
  logic [1:0] typ;

  int checks = 0;
  int failures = 0;

  // model: mode 0 = waiting for request, 1 = decision out, 2 = cooling down
  logic [7:0] m_lfsr;
  int         m_mode, m_left;
  logic       m_valid;
  logic [1:0] m_type;

  cpu_action_gen #(.LFSR_W(8), .SEED(8'h01), .HOLD_W(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_seed_load(sl), .i_seed(seed),
    .i_thr0(thr0), .i_thr1(thr1), .i_thr2(thr2), .i_hold(hold),
    .i_req(req), .i_ack(ack), .o_valid(valid), .o_cpu_type(typ), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] classify(input logic [7:0] r, t0, t1, t2);
    if (r <= t0) return 2'd0;
    if (r <= t1) return 2'd1;
    if (r <= t2) return 2'd2;
    return 2'd3;
  endfunction

  // taps 8,6,5,4 as a mask over bits 7..0
  function automatic logic [7:0] step_lfsr(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  task automatic model_reset();
    m_lfsr = 8'h01; m_mode = 0; m_left = 0; m_valid = 1'b0; m_type = 2'd0;
  endtask

  task automatic tick();
    logic [7:0] r;
    r = m_lfsr;
    if (m_mode == 0) begin
      if (req) begin m_type = classify(r, thr0, thr1, thr2); m_valid = 1'b1; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (ack) begin
        m_valid = 1'b0;
        if (hold == 0) m_mode = 0;
        else begin m_left = int'(hold); m_mode = 2; end
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = 0;
    end
    if (sl) m_lfsr = (seed == 0) ? 8'h01 : seed;
    else if (en) m_lfsr = step_lfsr(m_lfsr);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 0; sl = 0; seed = 0; req = 0; ack = 0; hold = 0;
    thr0 = 8'h10; thr1 = 8'h80; thr2 = 8'hC0;
    model_reset();
    #12;
    checks++;
    if (valid !== 1'b0 || typ !== 2'd0 || busy !== 1'b0 || dut.lfsr !== 8'h01) begin
      failures++;
      $display("FAIL reset_state got v=%b t=%0d b=%b l=%h exp 0/0/0/01", valid, typ, busy, dut.lfsr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sl = 1; seed = 8'hC8; tick(); sl = 0;
    req = 1; tick(); req = 0;
    checks++;
    if (valid !== 1'b1 || typ !== 2'd3) begin
      failures++;
      $display("FAIL reset_prep got v=%b t=%0d exp v=1 t=3", valid, typ);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || typ !== 2'd0 || busy !== 1'b0 || dut.lfsr !== 8'h01) begin
      failures++;
      $display("FAIL reset_mid_valid got v=%b t=%0d b=%b l=%h exp 0/0/0/01", valid, typ, busy, dut.lfsr);
    end
    model_reset();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_classify();
    logic [7:0] seeds [4] = '{8'hC8, 8'h10, 8'h81, 8'hC0};
    logic [1:0] exps  [4] = '{2'd3, 2'd0, 2'd2, 2'd2};
    en = 0; hold = 0; thr0 = 8'h10; thr1 = 8'h80; thr2 = 8'hC0;
    for (int i = 0; i < 4; i++) begin
      sl = 1; seed = seeds[i]; tick(); sl = 0;
      req = 1; tick(); req = 0;
      checks++;
      if (valid !== 1'b1 || typ !== exps[i]) begin
        failures++;
        $display("FAIL classify seed=%h got v=%b t=%0d exp v=1 t=%0d", seeds[i], valid, typ, exps[i]);
      end
      ack = 1; tick(); ack = 0;
      checks++;
      if (valid !== 1'b0 || typ !== exps[i]) begin
        failures++;
        $display("FAIL classify_ack got v=%b t=%0d exp v=0 t=%0d", valid, typ, exps[i]);
      end
    end
  endtask

  task automatic test_sequence();
    logic [7:0] exp_seq [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
    int n;
    en = 0; sl = 1; seed = 8'h00; tick(); sl = 0;
    checks++;
    if (dut.lfsr !== 8'h01) begin
      failures++;
      $display("FAIL zero_seed got %h exp 01", dut.lfsr);
    end
    en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut.lfsr !== exp_seq[i]) begin
        failures++;
        $display("FAIL lfsr_seq step=%0d got %h exp %h", i, dut.lfsr, exp_seq[i]);
      end
    end
    en = 0; sl = 1; seed = 8'h00; tick(); sl = 0; en = 1;
    n = 0;
    do begin tick(); n++; end while (dut.lfsr !== 8'h01 && n < 300);
    checks++;
    if (n != 255) begin
      failures++;
      $display("FAIL lfsr_period got %0d exp 255", n);
    end
    en = 0;
  endtask

  task automatic test_cooldown();
    logic       ev [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       eb [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    en = 1; hold = 8'd3; req = 1; tick();
    checks++;
    if (valid !== 1'b1) begin failures++; $display("FAIL cool_first got v=%b exp 1", valid); end
    ack = 1; tick(); ack = 0; hold = 8'd0;
    checks++;
    if (valid !== ev[0] || busy !== eb[0]) begin
      failures++;
      $display("FAIL cool_edge_m got v=%b b=%b exp v=%b b=%b", valid, busy, ev[0], eb[0]);
    end
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++;
      if (valid !== ev[i] || busy !== eb[i] || typ !== m_type) begin
        failures++;
        $display("FAIL cool_edge_m+%0d got v=%b b=%b t=%0d exp v=%b b=%b t=%0d",
                 i, valid, busy, typ, ev[i], eb[i], m_type);
      end
    end
    req = 0; ack = 1; tick(); ack = 0;
  endtask

  task automatic test_hold_stable();
    logic [1:0] t;
    en = 1; thr0 = 8'($urandom); thr1 = 8'($urandom); thr2 = 8'($urandom);
    req = 1; tick();
    t = typ;
    checks++;
    if (t !== m_type || valid !== 1'b1) begin
      failures++;
      $display("FAIL hold_first got t=%0d v=%b exp t=%0d v=1", t, valid, m_type);
    end
    for (int i = 0; i < 10; i++) begin
      req = 1'($urandom);
      tick();
      checks++;
      if (typ !== t || valid !== 1'b1) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got t=%0d v=%b exp t=%0d v=1", i, typ, valid, t);
      end
    end
    req = 0; hold = 0; ack = 1; tick();
    tick(); ack = 0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || typ !== t) begin
      failures++;
      $display("FAIL stray_ack got v=%b b=%b t=%0d exp v=0 b=0 t=%0d", valid, busy, typ, t);
    end
  endtask

  task automatic test_simul();
    logic [7:0] sd;
    logic [1:0] e;
    for (int k = 0; k < 4; k++) begin
      en = 1'($urandom); sd = 8'($urandom_range(1, 255));
      thr0 = 8'($urandom); thr1 = 8'($urandom); thr2 = 8'($urandom);
      e = classify(m_lfsr, thr0, thr1, thr2);
      sl = 1; seed = sd; req = 1; tick(); sl = 0; req = 0;
      checks++;
      if (typ !== e || valid !== 1'b1 || dut.lfsr !== sd) begin
        failures++;
        $display("FAIL seed_with_req got t=%0d v=%b l=%h exp t=%0d v=1 l=%h", typ, valid, dut.lfsr, e, sd);
      end
      hold = 0; ack = 1; tick(); ack = 0;
    end
  endtask

  task automatic test_all_ff();
    int bad = 0;
    thr0 = 8'hFF; thr1 = 8'hFF; thr2 = 8'hFF; hold = 0;
    for (int i = 0; i < 1000; i++) begin
      en = 1'($urandom);
      req = 1; tick(); req = 0;
      if (typ !== 2'd0 || valid !== 1'b1) bad++;
      ack = 1; tick(); ack = 0;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL all_ff_standby got %0d non-STANDBY decisions exp 0", bad);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin thr0 = 8'($urandom); thr1 = 8'($urandom); thr2 = 8'($urandom); end
      en = 1'($urandom); sl = ($urandom_range(0, 15) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      hold = 8'($urandom_range(0, 4)); req = 1'($urandom); ack = 1'($urandom);
      tick();
      checks++;
      if (valid !== m_valid || typ !== m_type || busy !== (m_mode != 0) || dut.lfsr !== m_lfsr) begin
        failures++;
        $display("FAIL random cyc=%0d got v=%b t=%0d b=%b l=%h exp v=%b t=%0d b=%b l=%h",
                 i, valid, typ, busy, dut.lfsr, m_valid, m_type, (m_mode != 0), m_lfsr);
      end
    end
    sl = 0; req = 0; ack = 0;
  endtask

  initial begin
    test_reset();
    test_classify();
    test_sequence();
    test_cooldown();
    test_hold_stable();
    test_simul();
    test_all_ff();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
